// File: rtl/ring_stop.sv
// ring_stop: one station of the unidirectional force-writeback ring.
//
// Local PE packets are accepted through a valid/ready handshake into an
// injection FIFO and inserted into free ring slots. Transit traffic is always
// forwarded without stalling. Packets addressed to this node are ejected to
// the local force cache write port, whether they arrive from the ring or come
// from this node's own FIFO.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pkt_in          packet from the local PE {dst, pid, fz, fy, fx}
//   pkt_valid       pkt_in valid
//   ready           injection FIFO not full
//   ring_in_data    slot from the upstream node
//   ring_in_valid   upstream slot occupied
//   ring_out_data   slot to the downstream node (registered)
//   ring_out_valid  downstream slot occupied (registered)
//   data_out        ejected {pid, fz, fy, fx} (registered)
//   data_valid      one-cycle write strobe for the local force cache
//   idle            FIFO empty and no outgoing slot
//   dst_error       sticky flag: an accepted packet had dst >= NUM_CELLS
module ring_stop #(
    parameter int NUM_CELLS         = 125,
    parameter int NODE_ID           = 0,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
    parameter int FIFO_DEPTH        = 8,
    localparam int FORCE_DATA_WIDTH = 3 * DATA_WIDTH + PARTICLE_ID_WIDTH,
    localparam int PACKET_WIDTH     = FORCE_DATA_WIDTH + NODE_ID_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PACKET_WIDTH-1:0]     pkt_in,
    input  logic                        pkt_valid,
    output logic                        ready,
    input  logic [PACKET_WIDTH-1:0]     ring_in_data,
    input  logic                        ring_in_valid,
    output logic [PACKET_WIDTH-1:0]     ring_out_data,
    output logic                        ring_out_valid,
    output logic [FORCE_DATA_WIDTH-1:0] data_out,
    output logic                        data_valid,
    output logic                        idle,
    output logic                        dst_error
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]      FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [NODE_ID_WIDTH-1:0] MY_ID      = NODE_ID_WIDTH'(NODE_ID);
    localparam logic [NODE_ID_WIDTH:0]   CELL_LIMIT = (NODE_ID_WIDTH + 1)'(NUM_CELLS);

    logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH:0]     count;

    logic [PACKET_WIDTH-1:0]  head;
    logic [NODE_ID_WIDTH-1:0] head_dst;
    logic [NODE_ID_WIDTH-1:0] ring_dst;
    logic [NODE_ID_WIDTH-1:0] in_dst;
    logic                     not_empty;
    logic                     ring_hit;
    logic                     ring_fwd;
    logic                     head_self;
    logic                     inject;
    logic                     self_pop;
    logic                     pop;
    logic                     accept;
    logic                     push;
    logic                     bad_dst;

    assign head      = mem[rd_ptr];
    assign head_dst  = head[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
    assign ring_dst  = ring_in_data[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
    assign in_dst    = pkt_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
    assign not_empty = (count != '0);

    // ready depends only on the registered count (and reset), so a pop in
    // the same cycle never lets an extra packet in.
    assign ready   = !rst && (count != FULL_COUNT);
    assign accept  = pkt_valid && ready;
    assign bad_dst = ({1'b0, in_dst} >= CELL_LIMIT);
    assign push    = accept && !bad_dst;

    // Arbitration: ring ejection > transit forward > head injection into a
    // free slot; a self-addressed head uses the eject port only when the
    // ring is not ejecting this cycle.
    assign ring_hit  = ring_in_valid && (ring_dst == MY_ID);
    assign ring_fwd  = ring_in_valid && (ring_dst != MY_ID);
    assign head_self = not_empty && (head_dst == MY_ID);
    assign inject    = not_empty && !head_self && !ring_fwd;
    assign self_pop  = head_self && !ring_hit;
    assign pop       = inject || self_pop;

    assign idle = !not_empty && !ring_out_valid;

    // NOTE: the FIFO storage has no reset; only pointers and count are
    // cleared, which is enough to make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
            data_valid     <= 1'b0;
            data_out       <= '0;
            dst_error      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (accept && bad_dst) begin
                dst_error <= 1'b1;
            end

            ring_out_valid <= ring_fwd || inject;
            if (ring_fwd) begin
                ring_out_data <= ring_in_data;
            end else if (inject) begin
                ring_out_data <= head;
            end

            data_valid <= ring_hit || self_pop;
            if (ring_hit) begin
                data_out <= ring_in_data[FORCE_DATA_WIDTH-1:0];
            end else if (self_pop) begin
                data_out <= head[FORCE_DATA_WIDTH-1:0];
            end
        end
    end

endmodule
